// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-channel round-robin arbiter.
// Burst locking (and the FSM state type's use) is enabled by defining ARB_LOCK_EN.
package rr_arb_pkg;

    localparam int unsigned N_CH = 4;

    // Channel index; doubles as the downstream 4:1 mux select.
    typedef logic [1:0] ch_idx_t;

    // Burst-lock state.
    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_st_t;

    // One-hot decode of a channel index.
    function automatic logic [N_CH-1:0] ch_onehot(input ch_idx_t idx);
        logic [N_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: the first requester at or after ptr wins.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         ptr,
    output logic            gnt_vld,
    output ch_idx_t         gnt_idx
);

    ch_idx_t cand;

    // Scan from farthest to nearest so the nearest requester is the last write and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = ptr;
        cand    = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = ptr + ch_idx_t'(k);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4_1.sv
// 4-channel round-robin arbiter with valid/ready handshakes and a registered output stage.
// Define ARB_LOCK_EN to enable burst locking and the in_last port.
module rr_arb_4_1
    import rr_arb_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_valid,
    output logic [N_CH-1:0] in_ready,
    input  logic [W-1:0]    in_data0,
    input  logic [W-1:0]    in_data1,
    input  logic [W-1:0]    in_data2,
    input  logic [W-1:0]    in_data3,
`ifdef ARB_LOCK_EN
    input  logic [N_CH-1:0] in_last,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [1:0]      out_sel
);

    ch_idx_t        ptr_q;
    logic           pick_vld;
    ch_idx_t        pick_idx;
    ch_idx_t        gnt;
    logic           load_en;
    logic           any_valid;
    logic           xfer;
    logic [W-1:0]   gnt_data;

    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    ch_idx_t        out_sel_q;

    assign load_en   = !out_valid_q || out_ready;
    assign any_valid = |in_valid;

    rr_pick4 u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

`ifdef ARB_LOCK_EN
    arb_st_t state_q, state_d;
    ch_idx_t lock_ch_q, lock_ch_d;

    // While locked the grant sticks to the burst owner even if it has dropped valid.
    assign gnt = (state_q == ST_LOCKED) ? lock_ch_q : pick_idx;

    // Lock FSM next state: enter on a non-last beat, leave on the owner's last beat.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer && !in_last[gnt]) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = gnt;
                end
            end
            ST_LOCKED: begin
                if (xfer && in_last[lock_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
    assign gnt = pick_idx;
`endif

    // Only the granted channel may see ready, and never while reset or stalled.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && any_valid) begin
            in_ready = ch_onehot(gnt);
        end
    end

    assign xfer = in_valid[gnt] && in_ready[gnt];

    // Data select for the granted channel.
    always_comb begin
        gnt_data = in_data0;
        unique case (gnt)
            2'd0: gnt_data = in_data0;
            2'd1: gnt_data = in_data1;
            2'd2: gnt_data = in_data2;
            2'd3: gnt_data = in_data3;
            default: gnt_data = in_data0;
        endcase
    end

    // Rotate priority past the channel just served; held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= gnt + 2'd1;
        end
    end

    // Output register: load on transfer, drain on consume, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_sel_q   <= gnt;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

    // pick_vld is implied by any_valid; kept for visibility in waveforms.
    logic unused_pick_vld;
    assign unused_pick_vld = pick_vld;

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed self-checking bench for rr_arb_4_1; the burst-lock section needs ARB_LOCK_EN.
module tb_rr_arb_4_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rr_arb_4_1 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
`ifdef ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                           input logic [3:0] d);
        chk({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
        chk({tag, ".sel"},   {6'd0, out_sel},   {6'd0, s});
        chk({tag, ".data"},  {4'd0, out_data},  {4'd0, d});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        in_data0  = 4'd1;
        in_data1  = 4'd2;
        in_data2  = 4'd3;
        in_data3  = 4'd4;

        // 1. Reset for two cycles; ready stays low even with requests present.
        tick();
        tick();
        chk_out("reset", 1'b0, 2'd0, 4'd0);
        chk("reset.in_ready", {4'd0, in_ready}, 8'h00);

        // 2. All channels requesting, downstream always ready.
        rst = 1'b0;
        #1;
        chk("rr.first_ready", {4'd0, in_ready}, 8'h01);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr.beat%0d", k), 1'b1, 2'(k % 4), 4'(k % 4 + 1));
        end

        // 3. Only channels 1 and 3 request, starting from ptr=0.
        rst      = 1'b1;
        in_valid = 4'b0000;
        tick();
        rst      = 1'b0;
        in_valid = 4'b1010;
        #1;
        chk("odd.ready0", {4'd0, in_ready}, 8'h02);
        tick();
        chk_out("odd.g0", 1'b1, 2'd1, 4'd2);
        chk("odd.ready1", {4'd0, in_ready}, 8'h08);
        tick();
        chk_out("odd.g1", 1'b1, 2'd3, 4'd4);
        chk("odd.ready2", {4'd0, in_ready}, 8'h02);
        tick();
        chk_out("odd.g2", 1'b1, 2'd1, 4'd2);

        // 4. Stall for three cycles, then release; ptr now 2.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        chk("stall.ready_now", {4'd0, in_ready}, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("stall.c%0d", k), 1'b1, 2'd1, 4'd2);
            chk($sformatf("stall.ready%0d", k), {4'd0, in_ready}, 8'h00);
        end
        out_ready = 1'b1;
        #1;
        chk("release.ready", {4'd0, in_ready}, 8'h04);
        tick();
        chk_out("release.b0", 1'b1, 2'd2, 4'd3);
        tick();
        chk_out("release.b1", 1'b1, 2'd3, 4'd4);

        // 5. Reset mid-stream drops the pending beat and clears ptr.
        in_valid = 4'b0100;
        rst      = 1'b1;
        tick();
        chk_out("midrst", 1'b0, 2'd0, 4'd0);
        rst      = 1'b0;
        in_valid = 4'b1111;
        #1;
        chk("midrst.ptr0", {4'd0, in_ready}, 8'h01);
        in_valid = 4'b0100;
        #1;
        chk("midrst.ready", {4'd0, in_ready}, 8'h04);
        tick();
        chk_out("midrst.grant", 1'b1, 2'd2, 4'd3);

        // No request with downstream ready: beat drains, sel/data hold.
        in_valid = 4'b0000;
        tick();
        chk_out("drain", 1'b0, 2'd2, 4'd3);

`ifdef ARB_LOCK_EN
        // 6. Burst lock on channel 1 with channels 0 and 2 competing.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 4'b0001;
        in_last  = 4'b1111;
        tick();
        chk_out("lock.pre", 1'b1, 2'd0, 4'd1);
        in_valid = 4'b0111;
        in_last  = 4'b0000;
        tick();
        chk_out("lock.b0", 1'b1, 2'd1, 4'd2);
        tick();
        chk_out("lock.b1", 1'b1, 2'd1, 4'd2);
        in_valid = 4'b0101;
        #1;
        chk("lock.idle_ready", {4'd0, in_ready}, 8'h02);
        tick();
        chk("lock.idle_valid", {7'd0, out_valid}, 8'h00);
        in_valid = 4'b0111;
        in_last  = 4'b0010;
        tick();
        chk_out("lock.b2", 1'b1, 2'd1, 4'd2);
        in_last  = 4'b1111;
        tick();
        chk_out("lock.after0", 1'b1, 2'd2, 4'd3);
        tick();
        chk_out("lock.after1", 1'b1, 2'd0, 4'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
